// File: rtl/camera_pkg.sv
// Shared constants and the Bayer quad-to-RGB colour mapping for the camera pipeline.
package camera_pkg;

  localparam int BAYER_RGGB = 0;
  localparam int BAYER_GRBG = 1;
  localparam int BAYER_GBRG = 2;
  localparam int BAYER_BGGR = 3;

  localparam int PIX_W   = 12;
  localparam int COORD_W = 12;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // p00/p01 come from the upper row, p10/p11 from the lower row; green is the truncated mean.
  function automatic rgb_t bayer_map(input int pattern,
                                     input logic [PIX_W-1:0] p00,
                                     input logic [PIX_W-1:0] p01,
                                     input logic [PIX_W-1:0] p10,
                                     input logic [PIX_W-1:0] p11);
    logic [PIX_W-1:0] ga;
    logic [PIX_W-1:0] gb;
    logic [PIX_W:0]   gs;
    rgb_t             q;
    case (pattern)
      BAYER_GRBG: begin q.r = p01; q.b = p10; ga = p00; gb = p11; end
      BAYER_GBRG: begin q.r = p10; q.b = p01; ga = p00; gb = p11; end
      BAYER_BGGR: begin q.r = p11; q.b = p00; ga = p01; gb = p10; end
      default:    begin q.r = p00; q.b = p11; ga = p01; gb = p10; end
    endcase
    gs  = {1'b0, ga} + {1'b0, gb};
    q.g = gs[PIX_W:1];
    return q;
  endfunction

endpackage

// File: rtl/camera_line_buffer.sv
// One-row line buffer: simple dual-port RAM, registered read, read-during-write returns the old word.
module camera_line_buffer
  import camera_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = 11,
  parameter int W     = PIX_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/camera_bayer_to_rgb.sv
// Bayer-to-RGB quad demosaic: one RGB pixel per complete 2x2 quad, half resolution in X and Y.
module camera_bayer_to_rgb
  import camera_pkg::*;
#(
  parameter int LINE_MAX      = 2048,
  parameter int BAYER_PATTERN = BAYER_RGGB
) (
  input  logic               CAMERA_PIXCLK,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [PIX_W-1:0]   in_data,
  input  logic               in_valid,
  output logic [PIX_W-1:0]   out_r,
  output logic [PIX_W-1:0]   out_g,
  output logic [PIX_W-1:0]   out_b,
  output logic [COORD_W-2:0] out_x,
  output logic [COORD_W-2:0] out_y,
  output logic               out_valid,
  output logic               out_sof
);

  localparam int AW = $clog2(LINE_MAX);
  localparam logic [COORD_W:0] LINE_LIM = (COORD_W+1)'(LINE_MAX);

  // Handshake: in_valid qualifies in_* for one cycle, out_valid is a one-cycle strobe; there is no backpressure.
  logic               in_range;
  logic [PIX_W-1:0]   rd_data;
  logic               s1_valid;
  logic               s1_emit;
  logic [COORD_W-2:0] s1_ox;
  logic [COORD_W-2:0] s1_oy;
  logic [PIX_W-1:0]   s1_data;
  logic [PIX_W-1:0]   top_prev;
  logic [PIX_W-1:0]   bot_prev;
  logic               prev_line_ok;
  logic               have_line;
  logic [COORD_W-1:0] last_y;
  rgb_t               quad;

  assign in_range = ({1'b0, in_x} < LINE_LIM);

  camera_line_buffer #(
    .DEPTH (LINE_MAX),
    .AW    (AW),
    .W     (PIX_W)
  ) u_line_buffer (
    .clk   (CAMERA_PIXCLK),
    .we    (in_valid & in_range),
    .waddr (in_x[AW-1:0]),
    .wdata (in_data),
    .re    (in_valid),
    .raddr (in_x[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb quad = bayer_map(BAYER_PATTERN, top_prev, rd_data, bot_prev, s1_data);

  // prev_line_ok is refreshed at column 0, so it is already current for the odd column of that line.
  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid     <= 1'b0;
      s1_emit      <= 1'b0;
      s1_ox        <= '0;
      s1_oy        <= '0;
      s1_data      <= '0;
      prev_line_ok <= 1'b0;
      have_line    <= 1'b0;
      last_y       <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_emit  <= in_valid & in_x[0] & in_y[0] & in_range & prev_line_ok;
      if (in_valid) begin
        s1_ox   <= in_x[COORD_W-1:1];
        s1_oy   <= in_y[COORD_W-1:1];
        s1_data <= in_data;
        if (in_x == '0) begin
          prev_line_ok <= (in_y != '0) && have_line && (last_y == in_y - COORD_W'(1));
          last_y       <= in_y;
          have_line    <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CAMERA_PIXCLK or negedge reset_n) begin
    if (!reset_n) begin
      top_prev  <= '0;
      bot_prev  <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end else begin
      if (s1_valid) begin
        top_prev <= rd_data;
        bot_prev <= s1_data;
      end
      out_valid <= s1_emit;
      out_sof   <= s1_emit && (s1_ox == '0) && (s1_oy == '0);
      if (s1_emit) begin
        out_r <= quad.r;
        out_g <= quad.g;
        out_b <= quad.b;
        out_x <= s1_ox;
        out_y <= s1_oy;
      end
    end
  end

endmodule

// File: tb/tb_camera_bayer_to_rgb.sv
// Bench for camera_bayer_to_rgb: four instances (one per Bayer pattern) share one input stream.
module tb_camera_bayer_to_rgb;

  localparam int E_W = 167;

  logic        clk;
  logic        reset_n;
  logic [11:0] in_x;
  logic [11:0] in_y;
  logic [11:0] in_data;
  logic        in_valid;
  logic [11:0] o_r [4];
  logic [11:0] o_g [4];
  logic [11:0] o_b [4];
  logic [10:0] o_x [4];
  logic [10:0] o_y [4];
  logic [3:0]  o_v;
  logic [3:0]  o_sof;

  logic [E_W-1:0] exp_q [$];
  int             due_q [$];
  logic [E_W-1:0] obs_q [$];
  logic [E_W-1:0] ref_q [$];
  logic [E_W-1:0] obs;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int out_cnt = 0;

  logic [11:0] fr [4][64];
  logic [11:0] d64 [256];
  logic [11:0] t1 [8];
  int          m_last;
  bit          m_have;
  bit          m_ok;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    camera_bayer_to_rgb #(
      .LINE_MAX      (2048),
      .BAYER_PATTERN (p)
    ) u_dut (
      .CAMERA_PIXCLK (clk),
      .reset_n       (reset_n),
      .in_x          (in_x),
      .in_y          (in_y),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .out_r         (o_r[p]),
      .out_g         (o_g[p]),
      .out_b         (o_b[p]),
      .out_x         (o_x[p]),
      .out_y         (o_y[p]),
      .out_valid     (o_v[p]),
      .out_sof       (o_sof[p])
    );
  end

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb obs = {o_sof[0], o_x[0], o_y[0],
                     o_r[0], o_g[0], o_b[0], o_r[1], o_g[1], o_b[1],
                     o_r[2], o_g[2], o_b[2], o_r[3], o_g[3], o_b[3]};

  task automatic chk(input string tag, input logic [E_W-1:0] o, input logic [E_W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [35:0] ref_rgb(input int pat, input logic [11:0] p00, p01, p10, p11);
    logic [11:0] r, b, g1, g2;
    int          g;
    case (pat)
      1:       begin r = p01; b = p10; g1 = p00; g2 = p11; end
      2:       begin r = p10; b = p01; g1 = p00; g2 = p11; end
      3:       begin r = p11; b = p00; g1 = p01; g2 = p10; end
      default: begin r = p00; b = p11; g1 = p01; g2 = p10; end
    endcase
    g = (int'(g1) + int'(g2)) / 2;
    return {r, 12'(g), b};
  endfunction

  function automatic logic [35:0] rgb_of(input logic [E_W-1:0] v, input int p);
    return v[143-36*p -: 36];
  endfunction

  task automatic push_quad(input int x, input int y);
    logic [E_W-1:0] e;
    e = {(x / 2 == 0 && y / 2 == 0), 11'(x / 2), 11'(y / 2), 144'b0};
    for (int p = 0; p < 4; p++)
      e[143-36*p -: 36] = ref_rgb(p, fr[(y-1)%4][x-1], fr[(y-1)%4][x], fr[y%4][x-1], fr[y%4][x]);
    exp_q.push_back(e);
    due_q.push_back(cyc + 2);
  endtask

  // Driver: present one pixel for one cycle and update the reference model
  task automatic send(input int x, input int y, input logic [11:0] d);
    in_x     = 12'(x);
    in_y     = 12'(y);
    in_data  = d;
    in_valid = 1'b1;
    fr[y%4][x] = d;
    if (x == 0) begin
      m_ok   = (y != 0) && m_have && (m_last == y - 1);
      m_last = y;
      m_have = 1'b1;
    end
    if ((x % 2 == 1) && (y % 2 == 1) && m_ok) push_quad(x, y);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    idle(5);
    chk(tag, E_W'(exp_q.size()), E_W'(0));
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    due_q.delete();
    m_have = 1'b0;
    m_ok   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_zero", E_W'({o_v, o_sof, o_r[0], o_g[0], o_b[0], o_x[0], o_y[0], o_r[3], o_b[3]}), E_W'(0));
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Scoreboard: pop expected results as the DUT produces them
  always @(negedge clk) begin
    if (reset_n) begin
      if (|o_v) begin
        chk("valid_all", E_W'(o_v), E_W'(4'hF));
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed %0h expected none", obs);
        end
        if (exp_q.size() != 0) begin
          chk("out_data", obs, exp_q.pop_front());
          chk("latency", E_W'(cyc), E_W'(due_q.pop_front()));
        end
        out_cnt++;
        obs_q.push_back(obs);
      end else if (due_q.size() != 0) begin
        checks++;
        assert (cyc <= due_q[0]) else begin
          errors++;
          $error("FAIL missing_out: observed none expected %0h", exp_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  initial begin
    t1 = '{12'd100, 12'd200, 12'd101, 12'd201, 12'd300, 12'd400, 12'd301, 12'd401};
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_data  = '0;
    m_have   = 1'b0;
    m_ok     = 1'b0;
    m_last   = 0;
    @(negedge clk);
    chk("reset_init", E_W'({o_v, o_sof, o_r[0], o_g[0], o_b[0], o_x[0], o_y[0]}), E_W'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // 4x2 frame, all patterns at once
    out_cnt = 0;
    obs_q.delete();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) send(x, y, t1[y*4+x]);
    drain("t1_drain");
    chk("t1_count", E_W'(out_cnt), E_W'(2));
    chk("t1_rggb_q0", E_W'(rgb_of(obs_q[0], 0)), E_W'({12'd100, 12'd250, 12'd400}));
    chk("t1_rggb_q1", E_W'(rgb_of(obs_q[1], 0)), E_W'({12'd101, 12'd251, 12'd401}));
    chk("t1_sof", E_W'({obs_q[0][166], obs_q[1][166]}), E_W'(2'b10));
    chk("t2_grbg", E_W'(rgb_of(obs_q[0], 1)), E_W'({12'd200, 12'd250, 12'd300}));
    chk("t2_gbrg", E_W'(rgb_of(obs_q[0], 2)), E_W'({12'd300, 12'd250, 12'd200}));
    chk("t2_bggr", E_W'(rgb_of(obs_q[0], 3)), E_W'({12'd400, 12'd250, 12'd100}));

    // Green truncation at both ends of the range
    obs_q.delete();
    send(0, 0, 12'd10);   send(1, 0, 12'd4095);
    send(0, 1, 12'd4094); send(1, 1, 12'd20);
    drain("t3a_drain");
    chk("t3_green_max", E_W'(rgb_of(obs_q[0], 0)), E_W'({12'd10, 12'd4094, 12'd20}));
    obs_q.delete();
    send(0, 0, 12'd5); send(1, 0, 12'd0);
    send(0, 1, 12'd1); send(1, 1, 12'd7);
    drain("t3b_drain");
    chk("t3_green_min", E_W'(rgb_of(obs_q[0], 0)), E_W'({12'd5, 12'd0, 12'd7}));

    // 5x3 frame: odd column and odd row dropped
    out_cnt = 0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 5; x++) send(x, y, 12'($urandom_range(0, 4095)));
    drain("t4_drain");
    chk("t4_count", E_W'(out_cnt), E_W'(2));

    // 64x4 frame without and with input bubbles
    for (int i = 0; i < 256; i++) d64[i] = 12'($urandom_range(0, 4095));
    out_cnt = 0;
    obs_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 64; x++) send(x, y, d64[y*64+x]);
    drain("t5a_drain");
    chk("t5a_count", E_W'(out_cnt), E_W'(64));
    ref_q = obs_q;
    out_cnt = 0;
    obs_q.delete();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 64; x++) begin
        if ($urandom_range(0, 1) == 1) idle(1);
        send(x, y, d64[y*64+x]);
      end
    drain("t5b_drain");
    chk("t5b_count", E_W'(out_cnt), E_W'(64));
    for (int i = 0; i < 64; i++) chk("t5_identical", obs_q[i], ref_q[i]);

    // Reset in the middle of row 1, just after a quad-completing pixel
    for (int x = 0; x < 8; x++) send(x, 0, 12'($urandom_range(0, 4095)));
    send(0, 1, 12'($urandom_range(0, 4095)));
    send(1, 1, 12'($urandom_range(0, 4095)));
    do_reset();
    out_cnt = 0;
    for (int y = 1; y < 4; y++)
      for (int x = 0; x < 8; x++) send(x, y, 12'($urandom_range(0, 4095)));
    drain("t6_drain");
    chk("t6_count", E_W'(out_cnt), E_W'(4));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
